// File: rtl/weight_multi_comp_cell.sv
// Systolic weight cell: sparse (index,value) dot products per neuron, drained onto a result chain with an upstream FIFO.
// Forwarding latency 1; no backpressure. `define WEIGHT_COMP_SATURATE_EN to clamp instead of wrap.
module weight_multi_comp_cell #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_AMOUNT = 2,
  parameter int NEURON_AMOUNT = 2,
  parameter logic [NEURON_AMOUNT*WEIGHT_AMOUNT*DATA_WIDTH-1:0] WEIGHTS = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] input_index,
  input  logic [DATA_WIDTH-1:0] input_value,
  input  logic [DATA_WIDTH:0]   input_result,
  input  logic                  input_enable,
  output logic [DATA_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0] output_value,
  output logic [DATA_WIDTH:0]   output_result,
  output logic                  output_enable
);

  localparam int CW   = (NEURON_AMOUNT > 1) ? $clog2(NEURON_AMOUNT) : 1;
  localparam int CNTW = $clog2(NEURON_AMOUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(NEURON_AMOUNT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                state;
  logic [CW-1:0]         drain_cnt;
  logic [DATA_WIDTH-1:0] acc      [NEURON_AMOUNT];
  logic [DATA_WIDTH-1:0] drain_q  [NEURON_AMOUNT];
  logic [DATA_WIDTH-1:0] fifo_mem [NEURON_AMOUNT];
  logic [CW-1:0]         rd_ptr, wr_ptr;
  logic [CNTW-1:0]       fifo_count;

  logic [DATA_WIDTH-1:0]   wsel      [NEURON_AMOUNT];
  logic [2*DATA_WIDTH-1:0] prod_full [NEURON_AMOUNT];
  logic [DATA_WIDTH-1:0]   prod      [NEURON_AMOUNT];
  logic [DATA_WIDTH:0]     sum_full  [NEURON_AMOUNT];
  logic [DATA_WIDTH-1:0]   sum       [NEURON_AMOUNT];

  logic stream_start, stream_end, draining, fifo_empty, push, pop;

  assign stream_start = input_enable & ~output_enable;
  assign stream_end   = output_enable & ~input_enable;
  // The drain owns the output slot on the stream-end edge as well as while in DRAIN.
  assign draining     = (state == DRAIN) | stream_end;
  assign fifo_empty   = (fifo_count == '0);
  assign push         = input_result[DATA_WIDTH] & (draining | ~fifo_empty);
  assign pop          = ~draining & ~fifo_empty;

  always_comb begin
    for (int n = 0; n < NEURON_AMOUNT; n++) begin
      wsel[n] = '0;
      // Out-of-range indices match nothing, so they contribute a zero product.
      for (int i = 0; i < WEIGHT_AMOUNT; i++) begin
        if (input_index == DATA_WIDTH'(i))
          wsel[n] = WEIGHTS[(n*WEIGHT_AMOUNT+i)*DATA_WIDTH +: DATA_WIDTH];
      end
      prod_full[n] = {{DATA_WIDTH{1'b0}}, wsel[n]} * {{DATA_WIDTH{1'b0}}, input_value};
`ifdef WEIGHT_COMP_SATURATE_EN
      prod[n]     = (|prod_full[n][2*DATA_WIDTH-1:DATA_WIDTH]) ? '1 : prod_full[n][DATA_WIDTH-1:0];
      sum_full[n] = {1'b0, acc[n]} + {1'b0, prod[n]};
      sum[n]      = sum_full[n][DATA_WIDTH] ? '1 : sum_full[n][DATA_WIDTH-1:0];
`else
      prod[n]     = prod_full[n][DATA_WIDTH-1:0];
      sum_full[n] = {1'b0, acc[n]} + {1'b0, prod[n]};
      sum[n]      = sum_full[n][DATA_WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NEURON_AMOUNT; n++) acc[n] <= '0;
    end else if (input_enable) begin
      for (int n = 0; n < NEURON_AMOUNT; n++)
        acc[n] <= stream_start ? prod[n] : sum[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_index  <= '0;
      output_value  <= '0;
      output_enable <= 1'b0;
      output_result <= '0;
      state         <= IDLE;
      drain_cnt     <= '0;
      for (int n = 0; n < NEURON_AMOUNT; n++) drain_q[n] <= '0;
    end else begin
      output_index  <= input_index;
      output_value  <= input_value;
      output_enable <= input_enable;
      if (state == DRAIN) begin
        output_result <= {1'b1, drain_q[drain_cnt]};
        if (drain_cnt == LAST) begin
          drain_cnt <= '0;
          if (stream_end) begin
            // Back-to-back drain: take a fresh snapshot, next edge emits its word 0.
            drain_q <= acc;
          end else begin
            state <= input_enable ? ACCUM : IDLE;
          end
        end else begin
          drain_cnt <= drain_cnt + CW'(1);
        end
      end else if (stream_end) begin
        output_result <= {1'b1, acc[0]};
        drain_q       <= acc;
        if (NEURON_AMOUNT > 1) begin
          state     <= DRAIN;
          drain_cnt <= CW'(1);
        end else begin
          state <= IDLE;
        end
      end else begin
        output_result <= fifo_empty ? input_result : {1'b1, fifo_mem[rd_ptr]};
        state         <= input_enable ? ACCUM : IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int n = 0; n < NEURON_AMOUNT; n++) fifo_mem[n] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= input_result[DATA_WIDTH-1:0];
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + CW'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + CW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
